track_sensor_conditioner: RTL and testbench
===========================================

# track_sensor_conditioner

Front-end stage for the railway crossing controller. Turns the four raw, asynchronous, bouncy track sensor lines into clean single-cycle event pulses (T1_S1, T1_S3, T2_S1, T2_S3), which feed the crossing FSM directly. It synchronises, debounces and edge-detects each line, then filters events through a per-track occupancy FSM so the controller only sees ordered approach/exit events.

## Interface

- DEB_CYCLES, 4: consecutive synchronised cycles a new level must hold before it is accepted; legal range 1..255.
- STUCK_CYCLES, 255: cycles a debounced level may stay high before it is flagged stuck; legal range 2..65535. Used only with STUCK_DETECT_EN.

Ports:

- clk  in  1  single system clock; all logic on its rising edge.
- rst_  in  1  asynchronous, active-low reset.
- raw_t1_s1, raw_t1_s3, raw_t2_s1, raw_t2_s3  in  1 each  raw sensor lines, asynchronous to clk.
- T1_S1, T1_S3, T2_S1, T2_S3  out  1 each  registered one-cycle event pulses.
- t1_busy, t2_busy  out  1 each  track occupied between the accepted S1 and the accepted S3.
- fault  out  4  sticky stuck-high flags; bit order {t2_s3, t2_s1, t1_s3, t1_s1}.

## Operation

- Synchroniser: each raw line passes through a 2-flop synchroniser.
- Debouncer (per line):
  - Holds a stable level and a counter of width $clog2(DEB_CYCLES+1).
  - When the synchronised value differs from the stable level, the counter increments. When it matches, the counter clears.
  - When the counter reaches DEB_CYCLES, the stable level takes the new value and the counter clears.
- Edge detect: a 0->1 change of the stable level is a rise event. Falling edges produce nothing.
- Per-track FSM, states IDLE and IN_ZONE:
  - IDLE, S1 rise: emit S1 pulse, go to IN_ZONE.
  - IDLE, S3 rise: no pulse, stay IDLE. This is a reverse or spurious event.
  - IN_ZONE, S3 rise: emit S3 pulse, go to IDLE.
  - IN_ZONE, S1 rise: no pulse, stay IN_ZONE.
  - S1 and S3 rise in the same cycle: IDLE acts on S1 only; IN_ZONE acts on S3 only. One pulse at most per track per cycle.
- busy = (state == IN_ZONE), registered.
- The two tracks are fully independent. Pulses on both tracks in the same cycle are legal.

## Timing

- Reset values: synchronisers 0; stable levels 0; counters 0; FSMs IDLE; all pulses 0; busy 0; fault 0. Reset asserts asynchronously at any time, including mid-debounce or IN_ZONE, and everything returns to these values.
- Latency: with the raw line high and stable from clock edge k, the pulse is high during the cycle after edge k+DEB_CYCLES+2. It lasts exactly one cycle.
- busy changes on the same edge the corresponding pulse rises.
- Glitch rejection: a synchronised excursion shorter than DEB_CYCLES cycles changes nothing.
- The counter never wraps. It is bounded by DEB_CYCLES.
- Re-trigger: after an accepted rise, a new rise requires the debounced level to fall (DEB_CYCLES cycles low) and then rise again.

## Configuration

- STUCK_DETECT_EN defined:
  - Per line, a saturating counter (width $clog2(STUCK_CYCLES+1)) counts cycles with the debounced level high. It clears when the level is low.
  - On reaching STUCK_CYCLES, the matching fault bit sets on that edge and stays set until reset.
  - While a line's fault bit is set, that line's rise events are ignored by the FSM.
  - A faulted S3 leaves its track in IN_ZONE, which is fail-safe: the gate stays closed.
- STUCK_DETECT_EN undefined: no stuck counters, fault is constant 4'b0000, and the FSMs never suppress events.

## Test plan

Bench parameters: DEB_CYCLES=4, STUCK_CYCLES=32.

1. **Reset mid-operation.** Assert rst_ low asynchronously while track 1 is IN_ZONE and T2_S1 debounce is mid-count. Required response: all outputs 0 immediately. After release, a clean raw_t2_s1 pulse still takes 7 edges to T2_S1.
2. **Normal passage.** raw_t1_s1 high for 10 cycles, then 20 cycles later raw_t1_s3 high for 10 cycles. Required response: T1_S1 one-cycle pulse 7 edges after the first high sample, t1_busy=1, then a T1_S3 pulse and t1_busy=0. T2 outputs stay 0.
3. **Glitch rejection.** raw_t2_s1 high for 3 cycles. Required response: T2_S1 never asserts and t2_busy stays 0. Repeat with 4 cycles: T2_S1 pulses once.
4. **Ordering.** raw_t1_s3 pulse in IDLE gives no T1_S3. A second raw_t1_s1 pulse while IN_ZONE gives no T1_S1. Simultaneous S1/S3 rises in IDLE give T1_S1 only.
5. **Both tracks.** Identical stimulus on raw_t1_s1 and raw_t2_s1. Required response: T1_S1 and T2_S1 pulse in the same cycle, and both busy flags rise.
6. **Stuck sensor (macro defined).** Hold raw_t1_s3 high for 50 cycles. Required response: fault[1] sets 32 cycles after the debounced level rose and stays set. A later raw_t1_s3 pulse gives no T1_S3. With the macro undefined, fault stays 0000.

Source files
------------

// File: rtl/track_sensor_conditioner.sv
// track_sensor_conditioner
// Front end for the railway crossing controller. Each of the four raw track
// sensor lines is synchronised, debounced and rise-detected, and the rises
// are then ordered by a per-track IDLE/IN_ZONE FSM. The FSM emits one-cycle
// S1 (approach) and S3 (exit) pulses.
// Optional feature: define STUCK_DETECT_EN to enable the sticky stuck-high
// detection. A faulted line's rises are ignored, and a faulted S3 keeps its
// track IN_ZONE so the gate stays closed.
// Internal line order (index 3..0): t2_s3, t2_s1, t1_s3, t1_s1.
module track_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       raw_t1_s1,
  input  logic       raw_t1_s3,
  input  logic       raw_t2_s1,
  input  logic       raw_t2_s3,
  output logic       T1_S1,
  output logic       T1_S3,
  output logic       T2_S1,
  output logic       T2_S3,
  output logic       t1_busy,
  output logic       t2_busy,
  output logic [3:0] fault
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, IN_ZONE = 1'b1} zone_t;

  logic [3:0]       raw;
  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [DEB_W-1:0] deb_cnt [4];
  logic [3:0]       rise;

  zone_t t1_state, t1_next;
  zone_t t2_state, t2_next;
  logic  t1_s1_next, t1_s3_next, t2_s1_next, t2_s3_next;

  assign raw = {raw_t2_s3, raw_t2_s1, raw_t1_s3, raw_t1_s1};

  // Two-flop synchroniser for the asynchronous sensor lines
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: a new level must persist DEB_CYCLES cycles; the counter clears
  // on the accepting edge so it never reaches past DEB_CYCLES
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            stable[i]  <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous debounced level, for rise detection
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) stable_d <= '0;
    else       stable_d <= stable;
  end

`ifdef STUCK_DETECT_EN
  localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);

  logic [STUCK_W-1:0] stuck_cnt [4];

  // Saturating high-time counters; the fault bit latches when a count reaches
  // STUCK_CYCLES and holds until reset
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fault <= '0;
      for (int i = 0; i < 4; i++) stuck_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!stable[i]) begin
          stuck_cnt[i] <= '0;
        end else if (stuck_cnt[i] != STUCK_W'(STUCK_CYCLES)) begin
          stuck_cnt[i] <= stuck_cnt[i] + 1'b1;
          if (stuck_cnt[i] == STUCK_W'(STUCK_CYCLES - 1)) fault[i] <= 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_d & ~fault;
`else
  if (STUCK_CYCLES < 2 || STUCK_CYCLES > 65535) begin : g_stuck_cycles_unused
  end

  assign fault = 4'b0000;
  assign rise  = stable & ~stable_d;
`endif

  // Track FSMs: IDLE accepts only S1, IN_ZONE accepts only S3, so a
  // simultaneous S1/S3 rise resolves to whichever the current state expects
  always_comb begin
    t1_next    = t1_state;
    t2_next    = t2_state;
    t1_s1_next = 1'b0;
    t1_s3_next = 1'b0;
    t2_s1_next = 1'b0;
    t2_s3_next = 1'b0;
    case (t1_state)
      IDLE:    if (rise[0]) begin t1_next = IN_ZONE; t1_s1_next = 1'b1; end
      IN_ZONE: if (rise[1]) begin t1_next = IDLE;    t1_s3_next = 1'b1; end
      default: t1_next = IDLE;
    endcase
    case (t2_state)
      IDLE:    if (rise[2]) begin t2_next = IN_ZONE; t2_s1_next = 1'b1; end
      IN_ZONE: if (rise[3]) begin t2_next = IDLE;    t2_s3_next = 1'b1; end
      default: t2_next = IDLE;
    endcase
  end

  // FSM state and registered event pulses update on the same edge
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      t1_state <= IDLE;
      t2_state <= IDLE;
      T1_S1    <= 1'b0;
      T1_S3    <= 1'b0;
      T2_S1    <= 1'b0;
      T2_S3    <= 1'b0;
    end else begin
      t1_state <= t1_next;
      t2_state <= t2_next;
      T1_S1    <= t1_s1_next;
      T1_S3    <= t1_s3_next;
      T2_S1    <= t2_s1_next;
      T2_S3    <= t2_s3_next;
    end
  end

  assign t1_busy = (t1_state == IN_ZONE);
  assign t2_busy = (t2_state == IN_ZONE);

endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Directed bench for track_sensor_conditioner (DEB_CYCLES=4, STUCK_CYCLES=32).
// Pulse counts and capture cycles are gathered once per clock, and each
// scenario task compares them with hand-derived values.
module tb_track_sensor_conditioner;

  logic       clk;
  logic       rst_;
  logic       raw_t1_s1, raw_t1_s3, raw_t2_s1, raw_t2_s3;
  logic       T1_S1, T1_S3, T2_S1, T2_S3;
  logic       t1_busy, t2_busy;
  logic [3:0] fault;

  int checks;
  int failures;
  int cyc;
  int n11, n13, n21, n23;
  int at11, at13, at21, at23;
  int at_fault;

  track_sensor_conditioner #(.DEB_CYCLES(4), .STUCK_CYCLES(32)) dut (
    .clk(clk), .rst_(rst_),
    .raw_t1_s1(raw_t1_s1), .raw_t1_s3(raw_t1_s3),
    .raw_t2_s1(raw_t2_s1), .raw_t2_s3(raw_t2_s3),
    .T1_S1(T1_S1), .T1_S3(T1_S3), .T2_S1(T2_S1), .T2_S3(T2_S3),
    .t1_busy(t1_busy), .t2_busy(t2_busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts();
    cyc = 0;
    n11 = 0; n13 = 0; n21 = 0; n23 = 0;
    at11 = -1; at13 = -1; at21 = -1; at23 = -1;
    at_fault = -1;
  endtask

  // Advance one clock and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (T1_S1 === 1'b1) begin n11++; at11 = cyc; end
    if (T1_S3 === 1'b1) begin n13++; at13 = cyc; end
    if (T2_S1 === 1'b1) begin n21++; at21 = cyc; end
    if (T2_S3 === 1'b1) begin n23++; at23 = cyc; end
    if (fault !== 4'b0000 && at_fault < 0) at_fault = cyc;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // lines order {t2_s3, t2_s1, t1_s3, t1_s1}
  task automatic pulse(input logic [3:0] lines, input int len);
    raw_t1_s1 = lines[0];
    raw_t1_s3 = lines[1];
    raw_t2_s1 = lines[2];
    raw_t2_s3 = lines[3];
    ticks(len);
    raw_t1_s1 = 1'b0;
    raw_t1_s3 = 1'b0;
    raw_t2_s1 = 1'b0;
    raw_t2_s3 = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rst_ = 1'b0;
    raw_t1_s1 = 1'b0; raw_t1_s3 = 1'b0; raw_t2_s1 = 1'b0; raw_t2_s3 = 1'b0;
    clear_counts();
    ticks(3);
    outs = {T1_S1, T1_S3, T2_S1, T2_S3, t1_busy, t2_busy, fault};
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", outs, 10'b0);
    end
    rst_ = 1'b1;
    ticks(5);
    outs = {T1_S1, T1_S3, T2_S1, T2_S3, t1_busy, t2_busy, fault};
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=%b", outs, 10'b0);
    end
  endtask

  task automatic test_normal_passage();
    clear_counts();
    pulse(4'b0001, 10);
    ticks(20);
    checks++;
    if (n11 !== 1 || at11 !== 7) begin
      failures++;
      $display("FAIL pass_t1_s1 got count=%0d cycle=%0d exp count=1 cycle=7", n11, at11);
    end
    checks++;
    if (t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL pass_busy_set got=%b exp=1", t1_busy);
    end
    pulse(4'b0010, 10);
    ticks(20);
    checks++;
    if (n13 !== 1 || at13 !== 37) begin
      failures++;
      $display("FAIL pass_t1_s3 got count=%0d cycle=%0d exp count=1 cycle=37", n13, at13);
    end
    checks++;
    if (t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL pass_busy_clear got=%b exp=0", t1_busy);
    end
    checks++;
    if (n21 !== 0 || n23 !== 0 || t2_busy !== 1'b0) begin
      failures++;
      $display("FAIL pass_t2_quiet got s1=%0d s3=%0d busy=%b exp 0 0 0", n21, n23, t2_busy);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    pulse(4'b0100, 3);
    ticks(15);
    checks++;
    if (n21 !== 0 || t2_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_3 got count=%0d busy=%b exp 0 0", n21, t2_busy);
    end
    clear_counts();
    pulse(4'b0100, 4);
    ticks(15);
    checks++;
    if (n21 !== 1 || at21 !== 7 || t2_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_4 got count=%0d cycle=%0d busy=%b exp 1 7 1", n21, at21, t2_busy);
    end
    clear_counts();
    pulse(4'b1000, 6);
    ticks(15);
    checks++;
    if (n23 !== 1 || at23 !== 7 || t2_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_exit got count=%0d cycle=%0d busy=%b exp 1 7 0", n23, at23, t2_busy);
    end
  endtask

  task automatic test_ordering();
    clear_counts();
    pulse(4'b0010, 6);
    ticks(15);
    checks++;
    if (n13 !== 0 || t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL order_s3_idle got count=%0d busy=%b exp 0 0", n13, t1_busy);
    end
    clear_counts();
    pulse(4'b0001, 6);
    ticks(15);
    checks++;
    if (n11 !== 1 || t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL order_s1_enter got count=%0d busy=%b exp 1 1", n11, t1_busy);
    end
    clear_counts();
    pulse(4'b0001, 6);
    ticks(15);
    checks++;
    if (n11 !== 0 || t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL order_s1_in_zone got count=%0d busy=%b exp 0 1", n11, t1_busy);
    end
    clear_counts();
    pulse(4'b0010, 6);
    ticks(15);
    checks++;
    if (n13 !== 1 || t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL order_s3_exit got count=%0d busy=%b exp 1 0", n13, t1_busy);
    end
    clear_counts();
    pulse(4'b0011, 6);
    ticks(15);
    checks++;
    if (n11 !== 1 || n13 !== 0 || t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL order_simultaneous got s1=%0d s3=%0d busy=%b exp 1 0 1", n11, n13, t1_busy);
    end
    clear_counts();
    pulse(4'b0010, 6);
    ticks(15);
    checks++;
    if (n13 !== 1 || t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL order_final_exit got count=%0d busy=%b exp 1 0", n13, t1_busy);
    end
  endtask

  task automatic test_both_tracks();
    clear_counts();
    pulse(4'b0101, 6);
    ticks(15);
    checks++;
    if (n11 !== 1 || n21 !== 1 || at11 !== 7 || at21 !== 7) begin
      failures++;
      $display("FAIL both_s1 got t1=%0d@%0d t2=%0d@%0d exp 1@7 1@7", n11, at11, n21, at21);
    end
    checks++;
    if (t1_busy !== 1'b1 || t2_busy !== 1'b1) begin
      failures++;
      $display("FAIL both_busy got t1=%b t2=%b exp 1 1", t1_busy, t2_busy);
    end
    clear_counts();
    pulse(4'b1010, 6);
    ticks(15);
    checks++;
    if (n13 !== 1 || n23 !== 1 || at13 !== at23 || t1_busy !== 1'b0 || t2_busy !== 1'b0) begin
      failures++;
      $display("FAIL both_s3 got t1=%0d@%0d t2=%0d@%0d busy=%b%b exp 1@7 1@7 00",
               n13, at13, n23, at23, t1_busy, t2_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] outs;
    clear_counts();
    pulse(4'b0001, 6);
    ticks(15);
    checks++;
    if (t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_busy got=%b exp=1", t1_busy);
    end
    raw_t2_s1 = 1'b1;
    ticks(4);
    #3 rst_ = 1'b0;
    #1;
    outs = {T1_S1, T1_S3, T2_S1, T2_S3, t1_busy, t2_busy, fault};
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL midrst_async got=%b exp=%b", outs, 10'b0);
    end
    raw_t2_s1 = 1'b0;
    ticks(3);
    rst_ = 1'b1;
    ticks(2);
    clear_counts();
    pulse(4'b0100, 6);
    ticks(10);
    checks++;
    if (n21 !== 1 || at21 !== 7 || t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got count=%0d cycle=%0d t1_busy=%b exp 1 7 0", n21, at21, t1_busy);
    end
    clear_counts();
    pulse(4'b1000, 6);
    ticks(15);
  endtask

  task automatic test_stuck();
    clear_counts();
    raw_t1_s3 = 1'b1;
    ticks(50);
    raw_t1_s3 = 1'b0;
    ticks(20);
`ifdef STUCK_DETECT_EN
    checks++;
    if (at_fault !== 38) begin
      failures++;
      $display("FAIL stuck_set_cycle got=%0d exp=38", at_fault);
    end
    checks++;
    if (fault !== 4'b0010 || n13 !== 0) begin
      failures++;
      $display("FAIL stuck_sticky got fault=%b s3=%0d exp 0010 0", fault, n13);
    end
    clear_counts();
    pulse(4'b0001, 6);
    ticks(15);
    checks++;
    if (n11 !== 1 || t1_busy !== 1'b1) begin
      failures++;
      $display("FAIL stuck_s1_ok got count=%0d busy=%b exp 1 1", n11, t1_busy);
    end
    clear_counts();
    pulse(4'b0010, 6);
    ticks(15);
    checks++;
    if (n13 !== 0 || t1_busy !== 1'b1 || fault !== 4'b0010) begin
      failures++;
      $display("FAIL stuck_s3_ignored got count=%0d busy=%b fault=%b exp 0 1 0010", n13, t1_busy, fault);
    end
`else
    checks++;
    if (at_fault !== -1 || fault !== 4'b0000) begin
      failures++;
      $display("FAIL nostuck_fault got first=%0d fault=%b exp -1 0000", at_fault, fault);
    end
    checks++;
    if (n13 !== 0 || t1_busy !== 1'b0) begin
      failures++;
      $display("FAIL nostuck_idle got s3=%0d busy=%b exp 0 0", n13, t1_busy);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normal_passage();
    test_glitch();
    test_ordering();
    test_both_tracks();
    test_reset_mid();
    test_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
